control_sequencer: RTL

- Downstream consumer of the instruction register's 4-bit opcode; sits between IR and every bus-attached unit.
- Runs a T-state counter (T0..T4) and combinationally decodes (T-state, opcode, flags) into a 16-bit one-hot-per-signal control word.
- Fetch, execute, early end-of-instruction and HLT behaviour all live here.

---
 rtl/sap_pkg.sv | 48 ++++
 rtl/microcode_rom.sv | 62 ++++++
 rtl/control_sequencer.sv | 61 ++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP-style control path: opcodes, control-word bit map, T-states.
package sap_pkg;

    localparam int unsigned T_W    = 3;
    localparam int unsigned T_MAX  = 4;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned OP_W   = 4;

    localparam logic [T_W-1:0] T0 = T_W'(0);
    localparam logic [T_W-1:0] T1 = T_W'(1);
    localparam logic [T_W-1:0] T2 = T_W'(2);
    localparam logic [T_W-1:0] T3 = T_W'(3);
    localparam logic [T_W-1:0] T4 = T_W'(4);

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam int unsigned CTRL_HLT = 0;
    localparam int unsigned CTRL_CE  = 1;   // pc_inc
    localparam int unsigned CTRL_CO  = 2;   // pc_out
    localparam int unsigned CTRL_J   = 3;   // pc_load
    localparam int unsigned CTRL_MI  = 4;
    localparam int unsigned CTRL_RO  = 5;
    localparam int unsigned CTRL_RI  = 6;
    localparam int unsigned CTRL_II  = 7;
    localparam int unsigned CTRL_IO  = 8;
    localparam int unsigned CTRL_AI  = 9;
    localparam int unsigned CTRL_AO  = 10;
    localparam int unsigned CTRL_BI  = 11;
    localparam int unsigned CTRL_EO  = 12;
    localparam int unsigned CTRL_SU  = 13;
    localparam int unsigned CTRL_OI  = 14;
    localparam int unsigned CTRL_FI  = 15;

    function automatic logic [CTRL_W-1:0] ctrl_bit(input int unsigned idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (T-state, opcode, flags) -> control word and end-of-instruction marker.
module microcode_rom
    import sap_pkg::*;
(
    input  logic [T_W-1:0]    t_state,
    input  logic [OP_W-1:0]   opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [CTRL_W-1:0] ctrl,
    output logic              last_step
);

    // Steps beyond an opcode's own end decode to zero with last_step set, so T4 always terminates.
    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        case (t_state)
            T0: ctrl = ctrl_bit(CTRL_CO) | ctrl_bit(CTRL_MI);
            T1: ctrl = ctrl_bit(CTRL_RO) | ctrl_bit(CTRL_II) | ctrl_bit(CTRL_CE);
            T2: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl      = ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_MI);
                        last_step = 1'b0;
                    end
                    OP_LDI: ctrl = ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_AI);
                    OP_JMP: ctrl = ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_J);
                    OP_JC:  ctrl = carry_flag ? (ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_J)) : '0;
                    OP_JZ:  ctrl = zero_flag  ? (ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_J)) : '0;
                    OP_OUT: ctrl = ctrl_bit(CTRL_AO) | ctrl_bit(CTRL_OI);
                    OP_HLT: begin
                        ctrl      = ctrl_bit(CTRL_HLT);
                        last_step = 1'b0;
                    end
                    default: ;
                endcase
            end
            T3: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA: ctrl = ctrl_bit(CTRL_RO) | ctrl_bit(CTRL_AI);
                    OP_ADD, OP_SUB: begin
                        ctrl      = ctrl_bit(CTRL_RO) | ctrl_bit(CTRL_BI);
                        last_step = 1'b0;
                    end
                    OP_STA: ctrl = ctrl_bit(CTRL_AO) | ctrl_bit(CTRL_RI);
                    default: ;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl = ctrl_bit(CTRL_EO) | ctrl_bit(CTRL_AI) | ctrl_bit(CTRL_FI);
                    if (opcode == OP_SUB) ctrl = ctrl | ctrl_bit(CTRL_SU);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter, halt latch and reset gating around the microcode ROM.
module control_sequencer
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [OP_W-1:0]   opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [CTRL_W-1:0] ctrl,
    output logic [T_W-1:0]    t_state,
    output logic              halted,
    output logic              instr_done
);

    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;
    logic              t_illegal;

    microcode_rom u_rom (
        .t_state    (t_state),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (rom_ctrl),
        .last_step  (rom_last)
    );

    assign t_illegal = (t_state > T_W'(T_MAX));

    // Reset and illegal states blank every driver; a latched halt overrides the decode.
    always_comb begin
        ctrl       = '0;
        instr_done = 1'b0;
        if (rst) begin
            if (halted) begin
                ctrl = ctrl_bit(CTRL_HLT);
            end else if (!t_illegal) begin
                ctrl       = rom_ctrl;
                instr_done = rom_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            t_state <= T0;
            halted  <= 1'b0;
        end else if (en && !halted) begin
            if (t_illegal || instr_done) begin
                t_state <= T0;
            end else if (t_state == T2 && opcode == OP_HLT) begin
                halted <= 1'b1;
            end else begin
                t_state <= t_state + T_W'(1);
            end
        end
    end

endmodule
